// File: rtl/rc5_key_mix.sv
// RC5 key-mixing loop over external S/L RAMs; trace ports oA/oB/oIter under RC5_KEY_MIX_TRACE_EN.
// Latency: 5 cycles per iteration, oDone 5*N_ITER+1 cycles after iStart is seen in IDLE.
// No backpressure; iStart low aborts to IDLE on the next edge, high after DONE holds the result.
module rc5_key_mix #(
  parameter int T = 16,
  parameter int W = 32,
  parameter int C = 4,
  localparam int T_LENGTH = $clog2(T),
  localparam int C_LENGTH = ($clog2(C) > 1) ? $clog2(C) : 1,
  localparam int N_ITER   = 3 * ((T > C) ? T : C),
  localparam int K_LENGTH = $clog2(N_ITER + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iStart,
  input  logic [W-1:0]        iS_data,
  output logic [W-1:0]        oS_data,
  output logic [T_LENGTH-1:0] oS_address,
  output logic                oS_we,
  input  logic [W-1:0]        iL_data,
  output logic [W-1:0]        oL_data,
  output logic [C_LENGTH-1:0] oL_address,
  output logic                oL_we,
  output logic                oDone
`ifdef RC5_KEY_MIX_TRACE_EN
  ,
  output logic [W-1:0]        oA,
  output logic [W-1:0]        oB,
  output logic [K_LENGTH-1:0] oIter
`endif
);

  localparam int SH = $clog2(W);
  localparam logic [T_LENGTH-1:0] T_LAST = T_LENGTH'(T - 1);
  localparam logic [C_LENGTH-1:0] C_LAST = C_LENGTH'(C - 1);
  localparam logic [K_LENGTH-1:0] K_LAST = K_LENGTH'(N_ITER - 1);
  localparam logic [SH-1:0]       ROT_A  = SH'(3);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, MIX_A, MIX_B, ADVANCE, DONE} state_t;

  state_t state, stateNxt;

  logic [W-1:0]        a, aNxt, b, bNxt, lReg, lRegNxt;
  logic [T_LENGTH-1:0] sIdx, sIdxNxt;
  logic [C_LENGTH-1:0] lIdx, lIdxNxt;
  logic [K_LENGTH-1:0] iter, iterNxt;
  logic [W-1:0]        sDataNxt, lDataNxt;
  logic [T_LENGTH-1:0] sAddrNxt;
  logic [C_LENGTH-1:0] lAddrNxt;
  logic                sWeNxt, lWeNxt, doneNxt;
  logic [W-1:0]        aMix, bMix, abSum;

  // Rotate left: the upper half of the doubled word shifted left is the rotation.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [SH-1:0] n);
    logic [2*W-1:0] dbl;
    dbl = {x, x} << n;
    return dbl[2*W-1:W];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    if (!iStart) begin
      stateNxt = IDLE;
    end else begin
      case (state)
        IDLE:    stateNxt = FETCH;
        FETCH:   stateNxt = WAIT;
        WAIT:    stateNxt = MIX_A;
        MIX_A:   stateNxt = MIX_B;
        MIX_B:   stateNxt = ADVANCE;
        ADVANCE: stateNxt = (iter == K_LAST) ? DONE : FETCH;
        DONE:    stateNxt = DONE;
        default: stateNxt = IDLE;
      endcase
    end
  end

  always_comb begin
    abSum    = a + b;
    aMix     = rotl(iS_data + a + b, ROT_A);
    bMix     = rotl(lReg + abSum, abSum[SH-1:0]);
    aNxt     = a;
    bNxt     = b;
    lRegNxt  = lReg;
    sIdxNxt  = sIdx;
    lIdxNxt  = lIdx;
    iterNxt  = iter;
    sDataNxt = oS_data;
    sAddrNxt = oS_address;
    sWeNxt   = oS_we;
    lDataNxt = oL_data;
    lAddrNxt = oL_address;
    lWeNxt   = oL_we;
    doneNxt  = oDone;
    if (!iStart) begin
      aNxt     = '0;
      bNxt     = '0;
      lRegNxt  = '0;
      sIdxNxt  = '0;
      lIdxNxt  = '0;
      iterNxt  = '0;
      sDataNxt = '0;
      sAddrNxt = '0;
      sWeNxt   = 1'b0;
      lDataNxt = '0;
      lAddrNxt = '0;
      lWeNxt   = 1'b0;
      doneNxt  = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          sAddrNxt = sIdx;
          lAddrNxt = lIdx;
          sWeNxt   = 1'b0;
          lWeNxt   = 1'b0;
        end
        MIX_A: begin
          aNxt     = aMix;
          lRegNxt  = iL_data;
          sDataNxt = aMix;
          sWeNxt   = 1'b1;
        end
        // a already holds the freshly mixed A here
        MIX_B: begin
          bNxt     = bMix;
          lDataNxt = bMix;
          lWeNxt   = 1'b1;
          sWeNxt   = 1'b0;
        end
        ADVANCE: begin
          lWeNxt  = 1'b0;
          sIdxNxt = (sIdx == T_LAST) ? '0 : sIdx + 1'b1;
          lIdxNxt = (lIdx == C_LAST) ? '0 : lIdx + 1'b1;
          iterNxt = iter + 1'b1;
          if (iter == K_LAST) doneNxt = 1'b1;
        end
        DONE: begin
          doneNxt = 1'b1;
          sWeNxt  = 1'b0;
          lWeNxt  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a          <= '0;
      b          <= '0;
      lReg       <= '0;
      sIdx       <= '0;
      lIdx       <= '0;
      iter       <= '0;
      oS_data    <= '0;
      oS_address <= '0;
      oS_we      <= 1'b0;
      oL_data    <= '0;
      oL_address <= '0;
      oL_we      <= 1'b0;
      oDone      <= 1'b0;
    end else begin
      a          <= aNxt;
      b          <= bNxt;
      lReg       <= lRegNxt;
      sIdx       <= sIdxNxt;
      lIdx       <= lIdxNxt;
      iter       <= iterNxt;
      oS_data    <= sDataNxt;
      oS_address <= sAddrNxt;
      oS_we      <= sWeNxt;
      oL_data    <= lDataNxt;
      oL_address <= lAddrNxt;
      oL_we      <= lWeNxt;
      oDone      <= doneNxt;
    end
  end

`ifdef RC5_KEY_MIX_TRACE_EN
  assign oA    = a;
  assign oB    = b;
  assign oIter = iter;
`endif

endmodule

// File: tb/tb_rc5_key_mix.sv
// Bench for rc5_key_mix: a T=4/C=2 instance for vectors and corner cases, a default instance for the full run.
module tb_rc5_key_mix;

  localparam logic [31:0] P32 = 32'hB7E15163;
  localparam logic [31:0] Q32 = 32'h9E3779B9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        aStart, aSWe, aLWe, aDone;
  logic [31:0] aSRd, aSWr, aLRd, aLWr;
  logic [1:0]  aSAddr;
  logic [0:0]  aLAddr;
  logic        bStart, bSWe, bLWe, bDone;
  logic [31:0] bSRd, bSWr, bLRd, bLWr;
  logic [3:0]  bSAddr;
  logic [1:0]  bLAddr;
`ifdef RC5_KEY_MIX_TRACE_EN
  logic [31:0] aA, aB, bA, bB;
  logic [3:0]  aIter;
  logic [5:0]  bIter;
`endif

  rc5_key_mix #(.T(4), .W(32), .C(2)) dutA (
    .clk(clk), .rst(rst), .iStart(aStart),
    .iS_data(aSRd), .oS_data(aSWr), .oS_address(aSAddr), .oS_we(aSWe),
    .iL_data(aLRd), .oL_data(aLWr), .oL_address(aLAddr), .oL_we(aLWe),
    .oDone(aDone)
`ifdef RC5_KEY_MIX_TRACE_EN
    , .oA(aA), .oB(aB), .oIter(aIter)
`endif
  );

  rc5_key_mix #(.T(16), .W(32), .C(4)) dutB (
    .clk(clk), .rst(rst), .iStart(bStart),
    .iS_data(bSRd), .oS_data(bSWr), .oS_address(bSAddr), .oS_we(bSWe),
    .iL_data(bLRd), .oL_data(bLWr), .oL_address(bLAddr), .oL_we(bLWe),
    .oDone(bDone)
`ifdef RC5_KEY_MIX_TRACE_EN
    , .oA(bA), .oB(bB), .oIter(bIter)
`endif
  );

  // Single-port synchronous RAMs, read-first; ld copies the preload arrays in.
  logic [31:0] memAS[4], memAL[2], memBS[16], memBL[4];
  logic [31:0] ldAS[4], ldAL[2], ldBS[16], ldBL[4];
  logic        ld = 1'b0;

  always @(posedge clk) begin
    if (ld) begin
      for (int q = 0; q < 4; q++)  memAS[q] <= ldAS[q];
      for (int q = 0; q < 2; q++)  memAL[q] <= ldAL[q];
      for (int q = 0; q < 16; q++) memBS[q] <= ldBS[q];
      for (int q = 0; q < 4; q++)  memBL[q] <= ldBL[q];
    end else begin
      if (aSWe) memAS[aSAddr] <= aSWr;
      if (aLWe) memAL[aLAddr] <= aLWr;
      if (bSWe) memBS[bSAddr] <= bSWr;
      if (bLWe) memBL[bLAddr] <= bLWr;
    end
    aSRd <= memAS[aSAddr];
    aLRd <= memAL[aLAddr];
    bSRd <= memBS[bSAddr];
    bLRd <= memBL[bLAddr];
  end

  typedef struct packed {logic [31:0] addr; logic [31:0] dat;} wr_t;
  wr_t gotS[$], gotL[$], expS[$], expL[$];
  int  overlapCnt = 0, longCnt = 0;
  logic prevSWe = 1'b0, prevLWe = 1'b0;

  always @(negedge clk) begin
    if (aSWe) gotS.push_back('{addr: 32'(aSAddr), dat: aSWr});
    if (aLWe) gotL.push_back('{addr: 32'(aLAddr), dat: aLWr});
    if ((aSWe && aLWe) || (bSWe && bLWe)) overlapCnt++;
    if ((aSWe && prevSWe) || (aLWe && prevLWe)) longCnt++;
    prevSWe = aSWe;
    prevLWe = aLWe;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: the textbook RC5 mixing loop on plain arrays.
  logic [31:0] mdlS[16], mdlL[4];

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    for (int q = 0; q < n % 32; q++) x = {x[30:0], x[31]};
    return x;
  endfunction

  task automatic mixModel(input int t, input int c);
    logic [31:0] a, b;
    int i, j;
    a = 0; b = 0; i = 0; j = 0;
    expS.delete();
    expL.delete();
    for (int k = 0; k < 3 * ((t > c) ? t : c); k++) begin
      a = rotl(mdlS[i] + a + b, 3);
      mdlS[i] = a;
      expS.push_back('{addr: 32'(i), dat: a});
      b = rotl(mdlL[j] + a + b, int'((a + b) % 32));
      mdlL[j] = b;
      expL.push_back('{addr: 32'(j), dat: b});
      i = (i + 1) % t;
      j = (j + 1) % c;
    end
  endtask

  task automatic doLoad();
    @(negedge clk); ld = 1'b1;
    @(negedge clk); ld = 1'b0;
  endtask

  task automatic chkIdleA(input string nm);
    chk({nm, "_s_we"}, 32'(aSWe), 0);
    chk({nm, "_l_we"}, 32'(aLWe), 0);
    chk({nm, "_done"}, 32'(aDone), 0);
    chk({nm, "_s_data"}, aSWr, 0);
    chk({nm, "_l_data"}, aLWr, 0);
    chk({nm, "_s_addr"}, 32'(aSAddr), 0);
    chk({nm, "_l_addr"}, 32'(aLAddr), 0);
  endtask

  // Runs dutA from the current RAM contents to completion, holds 20 cycles, then releases.
  task automatic runA(input string nm, input logic [31:0] firstS, input logic [31:0] firstL, input bit useFirst);
    int bs, bl, cyc, doneAt, drops;
    for (int q = 0; q < 4; q++) mdlS[q] = memAS[q];
    for (int q = 0; q < 2; q++) mdlL[q] = memAL[q];
    mixModel(4, 2);
    bs = gotS.size();
    bl = gotL.size();
    @(negedge clk); aStart = 1'b1;
    cyc = 0; doneAt = -1;
    while (cyc < 200 && doneAt < 0) begin
      @(posedge clk); #1; cyc++;
      if (aDone) doneAt = cyc;
    end
    chk({nm, "_done_cycle"}, doneAt, 61);
    drops = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!aDone || aSWe || aLWe) drops++;
    end
    chk({nm, "_hold"}, drops, 0);
    aStart = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_done_clear"}, 32'(aDone), 0);
    chk({nm, "_s_wr_count"}, gotS.size() - bs, expS.size());
    chk({nm, "_l_wr_count"}, gotL.size() - bl, expL.size());
    for (int q = 0; q < expS.size(); q++) begin
      chk($sformatf("%s_s_addr%0d", nm, q), (bs + q < gotS.size()) ? gotS[bs + q].addr : 'x, expS[q].addr);
      chk($sformatf("%s_s_dat%0d", nm, q), (bs + q < gotS.size()) ? gotS[bs + q].dat : 'x, expS[q].dat);
      chk($sformatf("%s_l_addr%0d", nm, q), (bl + q < gotL.size()) ? gotL[bl + q].addr : 'x, expL[q].addr);
      chk($sformatf("%s_l_dat%0d", nm, q), (bl + q < gotL.size()) ? gotL[bl + q].dat : 'x, expL[q].dat);
    end
    if (useFirst) begin
      chk({nm, "_first_s"}, (bs < gotS.size()) ? gotS[bs].dat : 'x, firstS);
      chk({nm, "_first_l"}, (bl < gotL.size()) ? gotL[bl].dat : 'x, firstL);
    end
    for (int q = 0; q < 4; q++) chk($sformatf("%s_ram_s%0d", nm, q), memAS[q], mdlS[q]);
    for (int q = 0; q < 2; q++) chk($sformatf("%s_ram_l%0d", nm, q), memAL[q], mdlL[q]);
  endtask

  typedef struct {
    logic [3:0][31:0] s;
    logic [1:0][31:0] l;
    logic [31:0]      firstS;
    logic [31:0]      firstL;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bs, bl, cyc, doneAt;
    rst = 1'b1; aStart = 1'b0; bStart = 1'b0;
    for (int q = 0; q < 16; q++) ldBS[q] = P32 + Q32 * q;
    for (int q = 0; q < 4; q++)  ldBL[q] = 0;

    vecs[0].s[0] = P32;
    for (int q = 1; q < 4; q++) vecs[0].s[q] = vecs[0].s[q-1] + Q32;
    vecs[0].l = '0;
    vecs[0].firstS = 32'hBF0A8B1D;
    vecs[0].firstL = 32'hB7E15163;
    for (int v = 1; v < 4; v++) begin
      for (int q = 0; q < 4; q++) vecs[v].s[q] = (v == 3) ? 32'hFFFFFFFF : $urandom;
      for (int q = 0; q < 2; q++) vecs[v].l[q] = (v == 3) ? 32'h0 : $urandom;
      vecs[v].firstS = rotl(vecs[v].s[0], 3);
      vecs[v].firstL = rotl(vecs[v].l[0] + vecs[v].firstS, int'(vecs[v].firstS % 32));
    end

    #2;
    chkIdleA("reset");
    chk("reset_b_done", 32'(bDone), 0);
    chk("reset_b_s_we", 32'(bSWe), 0);
    @(negedge clk); rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      for (int q = 0; q < 4; q++) ldAS[q] = vecs[v].s[q];
      for (int q = 0; q < 2; q++) ldAL[q] = vecs[v].l[q];
      doLoad();
      runA($sformatf("vec%0d", v), vecs[v].firstS, vecs[v].firstL, 1'b1);
    end

    // Abort during MIX_A of iteration 5 (cycle 28), then restart from the partial RAM.
    for (int q = 0; q < 4; q++) ldAS[q] = $urandom;
    for (int q = 0; q < 2; q++) ldAL[q] = $urandom;
    doLoad();
    for (int q = 0; q < 4; q++) mdlS[q] = memAS[q];
    for (int q = 0; q < 2; q++) mdlL[q] = memAL[q];
    mixModel(4, 2);
    bs = gotS.size(); bl = gotL.size();
    @(negedge clk); aStart = 1'b1;
    repeat (28) @(posedge clk);
    #1 aStart = 1'b0;
    @(posedge clk); #1;
    chkIdleA("abort");
    chk("abort_s_count", gotS.size() - bs, 5);
    chk("abort_l_count", gotL.size() - bl, 5);
    for (int q = 0; q < 5; q++) begin
      chk($sformatf("abort_s_dat%0d", q), (bs + q < gotS.size()) ? gotS[bs + q].dat : 'x, expS[q].dat);
      chk($sformatf("abort_l_dat%0d", q), (bl + q < gotL.size()) ? gotL[bl + q].dat : 'x, expL[q].dat);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("abort_quiet_s", gotS.size() - bs, 5);
    chk("abort_quiet_l", gotL.size() - bl, 5);
    runA("restart", 0, 0, 1'b0);

    // Asynchronous reset landing mid-cycle while oS_we is high.
    for (int q = 0; q < 4; q++) ldAS[q] = $urandom;
    for (int q = 0; q < 2; q++) ldAL[q] = $urandom;
    doLoad();
    bs = gotS.size(); bl = gotL.size();
    @(negedge clk); aStart = 1'b1;
    repeat (34) @(posedge clk);
    #1;
    chk("pre_rst_s_we", 32'(aSWe), 1);
    #2 rst = 1'b1;
    #1;
    chkIdleA("async_rst");
    aStart = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_count", gotS.size() - bs, 6);
    chk("rst_l_count", gotL.size() - bl, 6);
    runA("after_rst", 0, 0, 1'b0);

    // Full default-size schedule from the P32/Q32 table with an all-zero key.
    for (int q = 0; q < 16; q++) mdlS[q] = memBS[q];
    for (int q = 0; q < 4; q++)  mdlL[q] = memBL[q];
    chk("big_preload_s1", memBS[1], 32'h5618CB1C);
    mixModel(16, 4);
    @(negedge clk); bStart = 1'b1;
    cyc = 0; doneAt = -1;
    while (cyc < 400 && doneAt < 0) begin
      @(posedge clk); #1; cyc++;
      if (bDone) doneAt = cyc;
    end
    chk("big_done_cycle", doneAt, 241);
    for (int q = 0; q < 16; q++) chk($sformatf("big_ram_s%0d", q), memBS[q], mdlS[q]);
    for (int q = 0; q < 4; q++)  chk($sformatf("big_ram_l%0d", q), memBL[q], mdlL[q]);
    bStart = 1'b0;
    @(posedge clk); #1;
    chk("big_done_clear", 32'(bDone), 0);

    chk("we_overlap", overlapCnt, 0);
    chk("we_pulse_width", longCnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
